muskbus_mem_responder: RTL and testbench

Bus-side target that answers Muskbus block transactions from the cache's reader/writer pair and behaves as main memory. Holds a block-addressed backing store, accepts one read or write transaction at a time, returns 64-byte blocks as eight 64-bit beats after a fixed access latency, and acknowledges writes with a single completion beat. It sits on the `bus` side of the cache's bus mux and serves as both the system-level memory model and the far end of the protocol.

---
 rtl/muskbus_mem_responder_if.sv | 22 ++
 rtl/muskbus_mem_responder.sv | 126 ++++++++++++
 tb/tb_muskbus_mem_responder.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muskbus_mem_responder_if.sv
// Muskbus request/response channel between a block requester
// and a memory-side responder.
interface muskbus_mem_responder_if;
    logic        reqcyc;
    logic [63:0] req;
    logic [12:0] reqtag;
    logic        reqack;
    logic        respcyc;
    logic [63:0] resp;
    logic [12:0] resptag;
    logic        respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/muskbus_mem_responder.sv
// Main-memory model on the Muskbus: block store answering one
// read (8 beats after a fixed latency) or write (1 completion beat) at a time.
module muskbus_mem_responder #(
    parameter int LOG_BLOCKS = 10,
    parameter int LATENCY    = 4
) (
    input logic                   clk,
    input logic                   reset,
    muskbus_mem_responder_if.slave bus
);
    localparam int NBLK = 1 << LOG_BLOCKS;
    localparam int WW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        RD_WAIT,
        RD_RESP,
        WR_RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [2:0]            beat;
    logic [WW-1:0]         wait_cnt;
    logic [12:0]           tag;
    logic [63:0]           addr;
    logic [511:0]          stage;
    logic [511:0]          obuf;
    logic [511:0]          mem [NBLK];
    logic                  xfer;
    logic [LOG_BLOCKS-1:0] idx;

    assign xfer = bus.reqcyc && bus.reqack;
    assign idx  = addr[LOG_BLOCKS+5:6];

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next state and handshake/response outputs
    always_comb begin
        state_nx    = state;
        bus.reqack  = 1'b0;
        bus.respcyc = 1'b0;
        bus.resp    = '0;
        bus.resptag = '0;
        unique case (state)
            IDLE: begin
                bus.reqack = bus.reqcyc;
                if (bus.reqcyc)
                    state_nx = bus.reqtag[12] ? WR_DATA : RD_WAIT;
            end
            WR_DATA: begin
                bus.reqack = bus.reqcyc;
                if (bus.reqcyc && beat == 3'd7)
                    state_nx = WR_RESP;
            end
            RD_WAIT: begin
                if (wait_cnt == '0)
                    state_nx = RD_RESP;
            end
            RD_RESP: begin
                bus.respcyc = 1'b1;
                bus.resp    = obuf[{beat, 6'd0} +: 64];
                bus.resptag = tag;
                if (bus.respack && beat == 3'd7)
                    state_nx = IDLE;
            end
            WR_RESP: begin
                bus.respcyc = 1'b1;
                bus.resp    = addr;
                bus.resptag = tag;
                if (bus.respack)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // header latch, beat index and access-latency counter
    always_ff @(posedge clk) begin
        if (reset) begin
            beat     <= '0;
            wait_cnt <= '0;
            tag      <= '0;
            addr     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (xfer) begin
                        tag      <= bus.reqtag;
                        addr     <= {bus.req[63:6], 6'd0};
                        beat     <= '0;
                        wait_cnt <= WW'(LATENCY - 1);
                    end
                end
                WR_DATA: begin
                    if (xfer) beat <= beat + 3'd1;
                end
                RD_WAIT: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - WW'(1);
                    else                beat     <= '0;
                end
                RD_RESP: begin
                    if (bus.respack) beat <= beat + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // staging, whole-block commit and read-out buffer (store is never reset)
    always_ff @(posedge clk) begin
        if (!reset && state == WR_DATA && xfer) begin
            stage[{beat, 6'd0} +: 64] <= bus.req;
            if (beat == 3'd7)
                mem[idx] <= {bus.req, stage[447:0]};
        end
        if (!reset && state == RD_WAIT && wait_cnt == '0)
            obuf <= mem[idx];
    end
endmodule

// File: tb/tb_muskbus_mem_responder.sv
// Randomised and directed bench for muskbus_mem_responder against
// a transaction-level memory model with a per-cycle output compare.
module tb_muskbus_mem_responder;
    localparam int LB  = 10;
    localparam int LAT = 4;

    typedef struct {
        logic [63:0] d;
        logic [12:0] t;
        bit          dc;
        int          rdy;
    } exp_t;

    logic clk;
    logic reset;

    muskbus_mem_responder_if bus ();

    muskbus_mem_responder #(
        .LOG_BLOCKS(LB),
        .LATENCY   (LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          nchk = 0;
    int          nerr = 0;
    int          cyc = 0;
    bit          armed = 0;
    bit          mbusy = 0;
    bit          wphase = 0;
    int          wk = 0;
    logic [12:0] mtag;
    logic [63:0] maddr;
    logic [511:0] stg;
    logic [511:0] mm [int];
    exp_t        q [$];
    logic [63:0] got [$];
    logic [12:0] got_tag [$];
    int          nacks = 0;
    int          hdr_cyc = 0;
    int          rise_cyc = 0;
    int          last_pop = 0;
    bit          prev_rc = 0;
    int          ack_mode = 0;
    int          pat = 0;
    logic [63:0] wdat [8];

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic int bidx(logic [63:0] a);
        return int'(a[LB+5:6]);
    endfunction

    // model and compare at every falling edge
    always @(negedge clk) begin
        bit   exp_ack;
        exp_t e;
        int   i;
        cyc++;
        exp_ack = bus.reqcyc && !mbusy;
        if (armed) begin
            chk("reqack", bus.reqack, exp_ack);
            if (q.size() > 0 && cyc >= q[0].rdy) begin
                chk("respcyc", bus.respcyc, 1);
                if (!q[0].dc) chk("resp", bus.resp, q[0].d);
                chk("resptag", bus.resptag, q[0].t);
                if (bus.respack) begin
                    got.push_back(bus.resp);
                    got_tag.push_back(bus.resptag);
                    last_pop = cyc;
                    void'(q.pop_front());
                    if (q.size() == 0) mbusy = 0;
                end
            end else begin
                chk("respcyc_idle", bus.respcyc, 0);
                chk("resp_idle", bus.resp, 0);
                chk("resptag_idle", bus.resptag, 0);
            end
            if (bus.respcyc && !prev_rc) rise_cyc = cyc;
            prev_rc = bus.respcyc;
        end
        if (reset) begin
            armed  = 1;
            q.delete();
            mbusy  = 0;
            wphase = 0;
        end else if (armed && bus.reqcyc && exp_ack) begin
            nacks++;
            if (!wphase) begin
                hdr_cyc = cyc;
                mtag    = bus.reqtag;
                maddr   = {bus.req[63:6], 6'd0};
                if (bus.reqtag[12]) begin
                    wphase = 1;
                    wk     = 0;
                end else begin
                    mbusy = 1;
                    i     = bidx(bus.req);
                    for (int k = 0; k < 8; k++) begin
                        e.dc  = !mm.exists(i);
                        e.d   = e.dc ? 64'd0 : mm[i][k*64 +: 64];
                        e.t   = bus.reqtag;
                        e.rdy = cyc + LAT + 1;
                        q.push_back(e);
                    end
                end
            end else begin
                stg[wk*64 +: 64] = bus.req;
                wk++;
                if (wk == 8) begin
                    mm[bidx(maddr)] = stg;
                    e.d   = maddr;
                    e.t   = mtag;
                    e.dc  = 0;
                    e.rdy = cyc + 1;
                    q.push_back(e);
                    wphase = 0;
                    mbusy  = 1;
                end
            end
        end
    end

    // response consumer
    initial begin
        bus.respack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0: bus.respack = 1'b1;
                1: begin
                    bus.respack = (pat % 3 == 0);
                    pat++;
                end
                default: bus.respack = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic [12:0] t);
        bit ok;
        ok = 0;
        bus.reqcyc = 1'b1;
        bus.req    = d;
        bus.reqtag = t;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.reqack) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.reqcyc = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (!mbusy && !wphase && q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [63:0] a, input logic [11:0] id,
                            input int gap_at, input int gap_len, input bit rnd);
        send_beat(a, {1'b1, id});
        for (int k = 0; k < 8; k++) begin
            if (k == gap_at) begin
                repeat (gap_len) @(posedge clk);
                #1;
            end else if (rnd && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_beat(wdat[k], {1'b1, id});
        end
        wait_idle();
    endtask

    task automatic do_read(input logic [63:0] a, input logic [11:0] id);
        send_beat(a, {1'b0, id});
        wait_idle();
    endtask

    initial begin
        #3000000;
        chk("global_watchdog", 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] a;
        int          sel;
        reset      = 1'b1;
        bus.reqcyc = 1'b0;
        bus.req    = '0;
        bus.reqtag = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // request already pending in the first cycle after reset
        reset      = 1'b1;
        bus.reqcyc = 1'b1;
        bus.req    = 64'h5000;
        bus.reqtag = 13'h0000;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ack_first_cycle", bus.reqack, 1);
        @(posedge clk);
        #1;
        bus.reqcyc = 1'b0;
        wait_idle();

        // write 0x1040 then read back via an unaligned address
        for (int k = 0; k < 8; k++) wdat[k] = 64'h1111_1111_1111_1111 * (k + 1);
        got.delete();
        got_tag.delete();
        nacks = 0;
        do_write(64'h1040, 12'h005, -1, 0, 0);
        chk("wr_acks", nacks, 9);
        chk("wr_beats", got.size(), 1);
        chk("wr_resp", got[0], 64'h1040);
        chk("wr_tag", got_tag[0], 13'h1005);
        got.delete();
        got_tag.delete();
        do_read(64'h1047, 12'h006);
        chk("rd_latency", rise_cyc - hdr_cyc, LAT + 1);
        chk("rd_beats", got.size(), 8);
        chk("rd_w0", got[0], 64'h1111_1111_1111_1111);
        chk("rd_w3", got[3], 64'h4444_4444_4444_4444);
        chk("rd_w7", got[7], 64'h8888_8888_8888_8888);
        chk("rd_tag", got_tag[7], 13'h0006);

        // stalled consumer
        ack_mode = 1;
        pat      = 0;
        got.delete();
        do_read(64'h1040, 12'h011);
        chk("stall_beats", got.size(), 8);
        chk("stall_w1", got[1], 64'h2222_2222_2222_2222);
        chk("stall_w6", got[6], 64'h7777_7777_7777_7777);
        ack_mode = 0;

        // requester gap between data beats 3 and 4
        for (int k = 0; k < 8; k++) wdat[k] = {$urandom, $urandom};
        do_write(64'h3000, 12'h021, 4, 3, 0);
        got.delete();
        do_read(64'h3000, 12'h022);
        chk("gap_beats", got.size(), 8);
        for (int k = 0; k < 8; k++) chk("gap_word", got[k], wdat[k]);

        // reset abandons a partial write
        for (int k = 0; k < 8; k++) wdat[k] = 64'hA5A5_A5A5_A5A5_A5A5;
        do_write(64'h2000, 12'h031, -1, 0, 0);
        send_beat(64'h2000, 13'h1032);
        for (int k = 0; k < 5; k++) send_beat(64'hDEAD_0000 + 64'(k), 13'h1032);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        got.delete();
        do_read(64'h2000, 12'h033);
        chk("rst_beats", got.size(), 8);
        chk("rst_w0", got[0], 64'hA5A5_A5A5_A5A5_A5A5);
        chk("rst_w5", got[5], 64'hA5A5_A5A5_A5A5_A5A5);
        chk("rst_w7", got[7], 64'hA5A5_A5A5_A5A5_A5A5);

        // header waiting while a read streams out
        send_beat(64'h1040, 13'h0041);
        for (int n = 0; n < 50 && !bus.respcyc; n++) @(negedge clk);
        send_beat(64'h3000, 13'h0042);
        chk("hdr_after_last", hdr_cyc, last_pop + 1);
        wait_idle();

        // randomised traffic over a few aliased blocks
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 8; k++) wdat[k] = {$urandom, $urandom};
            do_write(64'(b + 16) << 6, 12'(b), -1, 0, 0);
        end
        ack_mode = 2;
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 3);
            a   = {$urandom, $urandom};
            a[LB+5:6] = LB'(sel + 16);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 8; k++) wdat[k] = {$urandom, $urandom};
                do_write(a, 12'($urandom), -1, 0, 1);
            end else begin
                do_read(a, 12'($urandom));
            end
        end
        ack_mode = 0;
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
